// File: rtl/fibo_pkg.sv
// -----------------------------------------------------------------------------
// fibo_pkg
// Shared definitions for the Fibonacci sequence controller:
//   - FIBO_WIDTH / FIBO_NW : default term width and term-index width
//   - fibo_state_t         : controller state encoding (IDLE, LOAD, CALC, DONE)
// -----------------------------------------------------------------------------
package fibo_pkg;

    localparam int FIBO_WIDTH = 8;
    localparam int FIBO_NW    = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } fibo_state_t;

endpackage

// File: rtl/fibo_datapath.sv
// -----------------------------------------------------------------------------
// fibo_datapath
// Holds the running Fibonacci pair (a, b) = (F(i), F(i+1)) together with
// sticky "this value no longer fits in WIDTH bits" flags for each register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : initialise a=0, b=1 and clear both overflow flags
//   step       : advance the pair one term (a<=b, b<=a+b)
//   a, b       : current pair, modulo 2^WIDTH
//   a_ovf      : true value of a exceeded 2^WIDTH-1
// -----------------------------------------------------------------------------
module fibo_datapath
    import fibo_pkg::*;
#(
    parameter int WIDTH = FIBO_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic             a_ovf
);

    logic [WIDTH:0] sum;
    logic           b_ovf;

    // One extra bit captures the carry out of the modular addition.
    assign sum = {1'b0, a} + {1'b0, b};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a     <= '0;
            b     <= '0;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
        end else if (load) begin
            a     <= '0;
            b     <= WIDTH'(1);
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
        end else if (step) begin
            a     <= b;
            b     <= sum[WIDTH-1:0];
            a_ovf <= b_ovf;
            // Once either operand has wrapped, every later term is also too
            // large, so the flag is sticky along the sequence.
            b_ovf <= a_ovf | b_ovf | sum[WIDTH];
        end
    end

endmodule

// File: rtl/fibo_seq_ctrl.sv
// -----------------------------------------------------------------------------
// fibo_seq_ctrl
// Computes F(n) iteratively, streaming every intermediate term F(1)..F(n)
// and reporting the final value and an overflow flag.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   start, n    : request F(n); accepted only when idle
//   abort       : cancel an in-flight computation (LOAD/CALC only)
//   busy        : high whenever not idle
//   term_valid  : one strobe per computed term, term carries its value
//   done        : one-cycle completion strobe
//   result      : F(n) mod 2^WIDTH, updated at the end of the done cycle
//   overflow    : F(n) did not fit in WIDTH bits, updated with result
// -----------------------------------------------------------------------------
module fibo_seq_ctrl
    import fibo_pkg::*;
#(
    parameter int WIDTH = FIBO_WIDTH,
    parameter int NW    = FIBO_NW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [NW-1:0]    n,
    input  logic             abort,
    output logic             busy,
    output logic             term_valid,
    output logic [WIDTH-1:0] term,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow
);

    fibo_state_t      state_reg;
    fibo_state_t      state_next;
    logic [NW-1:0]    n_reg;
    logic [NW-1:0]    cnt_reg;
    logic [NW-1:0]    cnt_inc;
    logic             last_step;
    logic             load;
    logic             step;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             a_ovf;

    assign load      = (state_reg == LOAD);
    assign step      = (state_reg == CALC);
    assign cnt_inc   = cnt_reg + NW'(1);
    // The exit happens when cnt+1 reaches n, which is always before cnt
    // could wrap, so the NW-bit counter is sufficient.
    assign last_step = (cnt_inc == n_reg);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                // An abort in the same cycle as start suppresses the request.
                if (start && !abort) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (n_reg != '0) begin
                    state_next = CALC;
                end else begin
                    state_next = DONE;
                end
            end
            CALC: begin
                if (abort) begin
                    state_next = IDLE;
                end else if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Completion wins over a concurrent abort.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            cnt_reg   <= '0;
            result    <= '0;
            overflow  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && start && !abort) begin
                n_reg <= n;
            end
            if (state_reg == LOAD) begin
                cnt_reg <= '0;
            end else if (state_reg == CALC) begin
                cnt_reg <= cnt_inc;
            end
            if (state_reg == DONE) begin
                result   <= a;
                overflow <= a_ovf;
            end
        end
    end

    fibo_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .a     (a),
        .b     (b),
        .a_ovf (a_ovf)
    );

    assign busy       = (state_reg != IDLE);
    assign term_valid = (state_reg == CALC);
    // Before an update, b holds F(cnt+1), the term produced by this cycle.
    assign term       = term_valid ? b : '0;
    assign done       = (state_reg == DONE);

endmodule

// File: tb/tb_fibo_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fibo_seq_ctrl
// Self-checking bench for fibo_seq_ctrl (WIDTH=8, NW=6). Expected term strobes
// and done cycles are queued when a start is driven; a monitor pops and
// compares them as the DUT emits them. Scenario tasks check result/overflow,
// busy and strobe counts inline.
// -----------------------------------------------------------------------------
module tb_fibo_seq_ctrl;

    localparam int WIDTH = 8;
    localparam int NW    = 6;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [NW-1:0]    n     = '0;
    logic             busy;
    logic             term_valid;
    logic [WIDTH-1:0] term;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             overflow;

    fibo_seq_ctrl #(
        .WIDTH (WIDTH),
        .NW    (NW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .n          (n),
        .abort      (abort),
        .busy       (busy),
        .term_valid (term_valid),
        .term       (term),
        .done       (done),
        .result     (result),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges so far; an observation at a falling edge
    // belongs to cycle cyc+1.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               cyc;
        logic [WIDTH-1:0] val;
    } exp_term_t;

    exp_term_t       exp_terms[$];
    int              exp_done[$];
    int              compared   = 0;
    int              mismatched = 0;
    int              done_seen  = 0;
    longint unsigned fib[0:63];

    // Scoreboard monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (term_valid) begin
                    compared++;
                    if (exp_terms.size() == 0) begin
                        mismatched++;
                        $display("FAIL term_strobe: got term %0d in cycle %0d, required no strobe", term, cyc + 1);
                    end else begin
                        exp_term_t e;
                        e = exp_terms.pop_front();
                        if (term !== e.val || cyc + 1 != e.cyc) begin
                            mismatched++;
                            $display("FAIL term_stream: got %0d in cycle %0d, required %0d in cycle %0d",
                                     term, cyc + 1, e.val, e.cyc);
                        end
                    end
                end
                if (done) begin
                    done_seen++;
                    compared++;
                    if (exp_done.size() == 0) begin
                        mismatched++;
                        $display("FAIL done_strobe: got done in cycle %0d, required none", cyc + 1);
                    end else begin
                        int ec;
                        ec = exp_done.pop_front();
                        if (cyc + 1 != ec) begin
                            mismatched++;
                            $display("FAIL done_cycle: got cycle %0d, required cycle %0d", cyc + 1, ec);
                        end
                    end
                end
            end
        end
    end

    // Drive a start at the next falling edge and queue what it should produce.
    task automatic do_start(input int nv, input int n_terms, input bit want_done, output int k);
        @(negedge clk);
        n     = nv[NW-1:0];
        start = 1'b1;
        k     = cyc + 1;
        for (int i = 0; i < n_terms; i++) begin
            exp_term_t t;
            t.cyc = k + 2 + i;
            t.val = WIDTH'(fib[i + 1]);
            exp_terms.push_back(t);
        end
        if (want_done) exp_done.push_back(k + 2 + nv);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        if (busy) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: busy=%0b after 200 cycles, required 0", name, busy);
        end
    endtask

    task automatic test_reset();
        int k;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        compared++;
        if ({busy, term_valid, term, done, result, overflow} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: busy=%0b tv=%0b term=%0d done=%0b result=%0d ovf=%0b, required all 0",
                     busy, term_valid, term, done, result, overflow);
        end
        // Start presented together with reset release: accepted on first edge.
        rst_n = 1'b1;
        n     = NW'(1);
        start = 1'b1;
        k     = cyc + 1;
        begin
            exp_term_t t;
            t.cyc = k + 2;
            t.val = WIDTH'(1);
            exp_terms.push_back(t);
        end
        exp_done.push_back(k + 3);
        @(negedge clk);
        start = 1'b0;
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_first_start: busy=%0b, required 1", busy);
        end
        wait_idle("reset_n1");
        compared++;
        if (result !== WIDTH'(1) || overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_n1_result: got %0d/%0b, required 1/0", result, overflow);
        end
    endtask

    task automatic test_run(input string name, input int nv);
        int k;
        logic [WIDTH-1:0] er;
        logic             eo;
        er = WIDTH'(fib[nv]);
        eo = (fib[nv] > longint'(2**WIDTH - 1));
        do_start(nv, nv, 1'b1, k);
        wait_idle(name);
        compared++;
        if (result !== er || overflow !== eo) begin
            mismatched++;
            $display("FAIL %s_result: got %0d/%0b, required %0d/%0b", name, result, overflow, er, eo);
        end
    endtask

    task automatic test_abort_calc();
        int k;
        int saved_done;
        logic [WIDTH-1:0] prev_res;
        logic             prev_ovf;
        prev_res   = WIDTH'(fib[14]);
        prev_ovf   = 1'b1;
        saved_done = done_seen;
        do_start(20, 4, 1'b0, k);
        repeat (4) @(negedge clk);       // now in the 4th CALC cycle
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_busy: busy=%0b, required 0", busy);
        end
        repeat (5) @(negedge clk);
        compared++;
        if (done_seen != saved_done || result !== prev_res || overflow !== prev_ovf) begin
            mismatched++;
            $display("FAIL abort_retain: dones=%0d result=%0d ovf=%0b, required dones=%0d result=%0d ovf=%0b",
                     done_seen - saved_done, result, overflow, 0, prev_res, prev_ovf);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int saved_done;
        saved_done = done_seen;
        do_start(10, 10, 1'b1, k);
        // Second request while busy must be dropped without altering n.
        start = 1'b1;
        n     = NW'(3);
        @(negedge clk);
        start = 1'b0;
        n     = '0;
        wait_idle("b2b");
        compared++;
        if (result !== WIDTH'(55) || done_seen - saved_done != 1) begin
            mismatched++;
            $display("FAIL b2b_result: got result=%0d dones=%0d, required result=55 dones=1",
                     result, done_seen - saved_done);
        end
        // Immediately following request from idle runs normally.
        test_run("b2b_next", 3);
    endtask

    task automatic test_abort_done();
        int k;
        int saved_done;
        saved_done = done_seen;
        do_start(2, 2, 1'b1, k);
        repeat (3) @(negedge clk);       // DONE cycle
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        compared++;
        if (busy !== 1'b0 || result !== WIDTH'(1) || done_seen - saved_done != 1) begin
            mismatched++;
            $display("FAIL abort_done: busy=%0b result=%0d dones=%0d, required 0/1/1",
                     busy, result, done_seen - saved_done);
        end
    endtask

    task automatic test_abort_start_idle();
        @(negedge clk);
        n     = NW'(5);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        compared++;
        if (busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_with_start: busy=%0b, required 0", busy);
        end
        repeat (8) @(negedge clk);
        compared++;
        if (result !== WIDTH'(1)) begin
            mismatched++;
            $display("FAIL abort_with_start_result: got %0d, required 1", result);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        do_start(20, 3, 1'b0, k);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({busy, term_valid, term, done, result, overflow} !== '0) begin
            mismatched++;
            $display("FAIL reset_mid_outputs: busy=%0b tv=%0b term=%0d done=%0b result=%0d ovf=%0b, required all 0",
                     busy, term_valid, term, done, result, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        test_run("after_reset_n5", 5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        fib[0] = 0;
        fib[1] = 1;
        for (int i = 2; i < 64; i++) fib[i] = fib[i-1] + fib[i-2];

        test_reset();
        test_run("n10", 10);
        test_run("n0", 0);
        test_run("n63", 63);
        test_run("n13", 13);
        test_run("n14", 14);
        test_abort_calc();
        test_back_to_back();
        test_abort_done();
        test_abort_start_idle();
        test_reset_mid();

        repeat (3) @(negedge clk);
        compared++;
        if (exp_terms.size() != 0 || exp_done.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_drain: %0d terms and %0d dones outstanding, required 0/0",
                     exp_terms.size(), exp_done.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
